// File: rtl/event_counter_snap.sv
// event_counter_snap: weighted event accumulator with coherent LO/HI snapshots; SNAP_REQ -> SNAP_ACK in 2 cycles.
// No request queueing (SNAP_REQ ignored while busy); define EVENT_COUNTER_SNAP_THRESH_EN to build the THRESH compare / THR_IRQ.
module event_counter_snap #(
    parameter int CNT_WIDTH  = 48,
    parameter int DATA_WIDTH = 32,
    parameter int INC_WIDTH  = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EVENT_VALID,
    input  logic [INC_WIDTH-1:0]  EVENT_INC,
    input  logic                  SNAP_REQ,
    input  logic                  CLEAR_ON_SNAP,
    input  logic [CNT_WIDTH-1:0]  THRESH,
    output logic                  SNAP_BUSY,
    output logic                  SNAP_ACK,
    output logic [DATA_WIDTH-1:0] SNAP_LO,
    output logic [DATA_WIDTH-1:0] SNAP_HI,
    output logic                  OVERFLOW,
    output logic                  THR_IRQ
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAPT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  clr_q, clr_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH:0]    sum;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] snap_lo_q, snap_lo_d;
    logic [DATA_WIDTH-1:0] snap_hi_q, snap_hi_d;
    logic                  clr_capt;

    always_comb begin
        sum       = {1'b0, acc_q} + (CNT_WIDTH+1)'(EVENT_INC);
        state_d   = state_q;
        clr_d     = clr_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        snap_lo_d = snap_lo_q;
        snap_hi_d = snap_hi_q;
        clr_capt  = 1'b0;

        // Carry out of the extra sum bit is the overflow condition.
        if (EVENT_VALID) begin
            if (sum[CNT_WIDTH]) begin
                acc_d = SATURATE ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[CNT_WIDTH-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (SNAP_REQ) begin
                    clr_d   = CLEAR_ON_SNAP;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                snap_lo_d = acc_q[DATA_WIDTH-1:0];
                snap_hi_d = DATA_WIDTH'(acc_q >> DATA_WIDTH);
                // Clearing keeps this cycle's event and beats a same-cycle overflow.
                if (clr_q) begin
                    clr_capt = 1'b1;
                    acc_d    = EVENT_VALID ? CNT_WIDTH'(EVENT_INC) : '0;
                    ovf_d    = 1'b0;
                end
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            clr_q     <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            snap_lo_q <= '0;
            snap_hi_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            snap_lo_q <= snap_lo_d;
            snap_hi_q <= snap_hi_d;
        end
    end

`ifdef EVENT_COUNTER_SNAP_THRESH_EN
    logic thr_q, thr_d;
    logic hit_now, hit_new;

    // A clearing snapshot only drops the flag when the post-clear count is below THRESH.
    always_comb begin
        hit_now = (acc_q >= THRESH);
        hit_new = (acc_d >= THRESH);
        thr_d   = clr_capt ? (hit_new & (thr_q | hit_now)) : (thr_q | hit_now);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            thr_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
        end
    end

    assign THR_IRQ = thr_q;
`else
    logic unused_thresh;
    logic unused_clr_capt;
    assign unused_thresh   = ^THRESH;
    assign unused_clr_capt = clr_capt;
    assign THR_IRQ         = 1'b0;
`endif

    assign SNAP_BUSY = (state_q != ST_IDLE);
    assign SNAP_ACK  = (state_q == ST_ACK);
    assign SNAP_LO   = snap_lo_q;
    assign SNAP_HI   = snap_hi_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_event_counter_snap.sv
// Bench for event_counter_snap: table-driven snapshots with a scoreboard, plus overflow, reset and threshold sequences.
module tb_event_counter_snap;

`ifdef EVENT_COUNTER_SNAP_THRESH_EN
    localparam logic THR_EN = 1'b1;
`else
    localparam logic THR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ev_vld;
    logic [3:0]  ev_inc;
    logic        snap_req;
    logic        clr;
    logic [47:0] thresh;
    logic        busy, ack, ovf, thr;
    logic [31:0] lo, hi;

    logic        big_vld;
    logic [47:0] big_inc;
    logic        big_req;
    logic        big_clr;
    logic        s_busy, s_ack, s_ovf, s_thr;
    logic [31:0] s_lo, s_hi;
    logic        w_busy, w_ack, w_ovf, w_thr;
    logic [31:0] w_lo, w_hi;

    int checks   = 0;
    int failures = 0;

    event_counter_snap dut (
        .CLK(clk), .RST(rst), .EVENT_VALID(ev_vld), .EVENT_INC(ev_inc),
        .SNAP_REQ(snap_req), .CLEAR_ON_SNAP(clr), .THRESH(thresh),
        .SNAP_BUSY(busy), .SNAP_ACK(ack), .SNAP_LO(lo), .SNAP_HI(hi),
        .OVERFLOW(ovf), .THR_IRQ(thr)
    );

    event_counter_snap #(.INC_WIDTH(48), .SATURATE(1'b1)) dut_sat (
        .CLK(clk), .RST(rst), .EVENT_VALID(big_vld), .EVENT_INC(big_inc),
        .SNAP_REQ(big_req), .CLEAR_ON_SNAP(big_clr), .THRESH(thresh),
        .SNAP_BUSY(s_busy), .SNAP_ACK(s_ack), .SNAP_LO(s_lo), .SNAP_HI(s_hi),
        .OVERFLOW(s_ovf), .THR_IRQ(s_thr)
    );

    event_counter_snap #(.INC_WIDTH(48), .SATURATE(1'b0)) dut_wrap (
        .CLK(clk), .RST(rst), .EVENT_VALID(big_vld), .EVENT_INC(big_inc),
        .SNAP_REQ(big_req), .CLEAR_ON_SNAP(big_clr), .THRESH(thresh),
        .SNAP_BUSY(w_busy), .SNAP_ACK(w_ack), .SNAP_LO(w_lo), .SNAP_HI(w_hi),
        .OVERFLOW(w_ovf), .THR_IRQ(w_thr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          ncyc;
        logic [3:0]  inc;
        logic        clr;
        logic [3:0]  capt_inc;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ev_vld   = 1'b0;
        snap_req = 1'b0;
        clr      = 1'b0;
        big_vld  = 1'b0;
        big_req  = 1'b0;
        big_clr  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Request a snapshot on the main DUT; an event of ci is presented in the CAPT cycle.
    task automatic do_snap(input logic c, input logic [3:0] ci, input exp_t e);
        int   lat;
        logic got;
        exp_t x;
        snap_req = 1'b1;
        clr      = c;
        ev_vld   = 1'b0;
        sb_q.push_back(e);
        lat = 0;
        got = 1'b0;
        while (lat < 6 && !got) begin
            tick();
            lat++;
            snap_req = 1'b0;
            clr      = 1'b0;
            if (lat == 1) begin
                chk("busy_in_capt", busy, 1);
                ev_vld = 1'b1;
                ev_inc = ci;
            end else begin
                ev_vld = 1'b0;
            end
            if (ack) got = 1'b1;
        end
        chk("ack_latency", lat, 2);
        if (got) begin
            x = sb_q.pop_front();
            chk("snap_lo", lo, x.lo);
            chk("snap_hi", hi, x.hi);
            chk("snap_ovf", ovf, x.ovf);
            chk("busy_in_ack", busy, 1);
        end else begin
            void'(sb_q.pop_front());
        end
        tick();
        chk("ack_one_cycle", ack, 0);
        chk("busy_back_idle", busy, 0);
    endtask

    // Snapshot on both wide-increment instances; no event in the CAPT cycle unless ci != 0.
    task automatic big_snap(input logic c, input logic [3:0] ci,
                            input logic [31:0] slo, input logic [31:0] shi, input logic sov,
                            input logic [31:0] wlo, input logic [31:0] whi, input logic wov);
        int   lat;
        logic got;
        big_req = 1'b1;
        big_clr = c;
        big_vld = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 6 && !got) begin
            tick();
            lat++;
            big_req = 1'b0;
            big_clr = 1'b0;
            big_vld = (lat == 1) && (ci != 4'd0);
            big_inc = 48'(ci);
            if (s_ack) got = 1'b1;
        end
        chk("big_ack_latency", lat, 2);
        chk("wrap_ack", w_ack, 1);
        chk("sat_lo", s_lo, slo);
        chk("sat_hi", s_hi, shi);
        chk("sat_ovf", s_ovf, sov);
        chk("wrap_lo", w_lo, wlo);
        chk("wrap_hi", w_hi, whi);
        chk("wrap_ovf", w_ovf, wov);
        big_vld = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        ev_inc  = 4'd0;
        big_inc = 48'd0;
        thresh  = {48{1'b1}};

        // {cycles, inc, clear, CAPT-cycle inc, expected snapshot}
        vecs[0] = '{10, 4'd3,  1'b0, 4'd0, '{32'd30,  32'd0, 1'b0}};
        vecs[1] = '{5,  4'd2,  1'b0, 4'd4, '{32'd40,  32'd0, 1'b0}};
        vecs[2] = '{0,  4'd0,  1'b1, 4'd0, '{32'd44,  32'd0, 1'b0}};
        vecs[3] = '{10, 4'd10, 1'b1, 4'd7, '{32'd100, 32'd0, 1'b0}};
        vecs[4] = '{3,  4'd0,  1'b0, 4'd1, '{32'd7,   32'd0, 1'b0}};
        vecs[5] = '{4,  4'd15, 1'b0, 4'd0, '{32'd68,  32'd0, 1'b0}};

        rst      = 1'b1;
        ev_vld   = 1'b0;
        snap_req = 1'b0;
        clr      = 1'b0;
        big_vld  = 1'b0;
        big_req  = 1'b0;
        big_clr  = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_lo", lo, 0);
        chk("rst_hi", hi, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_thr", thr, 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                ev_vld = 1'b1;
                ev_inc = vecs[v].inc;
                tick();
            end
            ev_vld = 1'b0;
            do_snap(vecs[v].clr, vecs[v].capt_inc, vecs[v].exp);
        end
        chk("thr_never_set", thr, 0);

        // Three back-to-back requests yield a single acknowledge.
        acks = 0;
        snap_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            snap_req = (k < 2);
            if (ack) acks++;
        end
        chk("triple_req_acks", acks, 1);
        chk("triple_req_lo", lo, 68);

        // Reset while in CAPT aborts the snapshot.
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_lo", lo, 0);
        chk("abort_hi", hi, 0);
        chk("abort_ovf", ovf, 0);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack) acks++;
        end
        chk("abort_no_ack", acks, 0);

        // Threshold: 10 per cycle against THRESH=50.
        thresh = 48'd50;
        do_reset();
        ev_vld = 1'b1;
        ev_inc = 4'd10;
        for (int k = 0; k < 5; k++) tick();
        chk("thr_at_50", thr, 0);
        tick();
        ev_vld = 1'b0;
        chk("thr_rise", thr, THR_EN);
        for (int k = 0; k < 3; k++) tick();
        chk("thr_sticky", thr, THR_EN);
        do_snap(1'b1, 4'd0, '{32'd60, 32'd0, 1'b0});
        chk("thr_cleared", thr, 0);
        tick();
        chk("thr_stays_clear", thr, 0);

        thresh = 48'd0;
        rst = 1'b1;
        tick();
        chk("thr0_in_reset", thr, 0);
        rst = 1'b0;
        tick();
        chk("thr0_after_release", thr, THR_EN);
        thresh = {48{1'b1}};

        // Wide increments: LO/HI split across the 2^32 boundary.
        do_reset();
        big_vld = 1'b1;
        big_inc = 48'h0000_FFFF_FFFE;
        tick();
        big_inc = 48'd5;
        tick();
        big_vld = 1'b0;
        big_snap(1'b0, 4'd0, 32'h3, 32'h1, 1'b0, 32'h3, 32'h1, 1'b0);

        // Overflow: saturate vs wrap.
        do_reset();
        big_vld = 1'b1;
        big_inc = 48'hFFFF_FFFF_FFFE;
        tick();
        big_vld = 1'b0;
        chk("sat_ovf_pre", s_ovf, 0);
        chk("wrap_ovf_pre", w_ovf, 0);
        big_vld = 1'b1;
        big_inc = 48'd4;
        tick();
        big_vld = 1'b0;
        chk("sat_ovf_set", s_ovf, 1);
        chk("wrap_ovf_set", w_ovf, 1);
        big_snap(1'b0, 4'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'h2, 32'h0, 1'b1);
        // Clearing snapshot with an event that would overflow the saturated count: clear wins.
        big_snap(1'b1, 4'd1, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h2, 32'h0, 1'b0);
        big_snap(1'b0, 4'd0, 32'h1, 32'h0, 1'b0, 32'h1, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
